uart_rx_frame_chk: RTL and testbench
====================================

# uart_rx_frame_chk

Parametrised UART receive frame checker that generalises the single start-bit check into full-frame validation. It takes the per-bit samples produced by the RX data sampler and tracks its own position in the frame. It checks start, parity (even/odd/none) and one or two stop bits, and assembles a DATA_WIDTH-bit word. It sits between the RX sampler and the RX FSM/register-file interface, and it also keeps saturating error counters for system status readback.

## Interface
- DATA_WIDTH, 8, data bits per frame, legal 5..9
- CNT_WIDTH, 8, width of each error counter
- clk  input  1  system RX clock
- rst  input  1  asynchronous, active-high reset
- chk_en  input  1  checker enable; low forces IDLE
- done  input  1  one-cycle strobe: sampled_bit holds a valid bit sample
- sampled_bit  input  1  majority-voted bit value
- par_en  input  1  parity bit present in frame
- par_typ  input  1  0 = even, 1 = odd
- two_stop  input  1  1 = two stop bits
- clr_cnt  input  1  synchronous clear of all counters
- data_out  output  DATA_WIDTH  last received word, LSB first on the line
- data_vld  output  1  one-cycle pulse, frame complete
- strt_glitch  output  1  one-cycle pulse, start sample was 1
- par_err  output  1  parity error, valid with data_vld
- stp_err  output  1  stop error, valid with data_vld
- busy  output  1  state != IDLE
- glitch_cnt, par_err_cnt, stp_err_cnt  output  CNT_WIDTH each  saturating error counts

## Operation
- States: IDLE, DATA, PARITY, STOP1, STOP2.
- A done is consumed only when chk_en=1. When chk_en=0, done is ignored, and any state returns to IDLE on the next edge. No pulses are produced on that return, and the partial word is discarded.
- IDLE, done with sampled_bit=0: go to DATA and clear bit_cnt. par_en, par_typ and two_stop are latched here and hold for the whole frame.
- IDLE, done with sampled_bit=1: pulse strt_glitch, increment glitch_cnt, stay in IDLE.
- DATA: each done shifts sampled_bit into bit position bit_cnt (LSB first). After DATA_WIDTH bits, go to PARITY if par_en (latched) is set, otherwise go to STOP1.
- PARITY: the expected bit is the XOR of the data bits, inverted when par_typ=1. On mismatch the internal par_flag is set. Then go to STOP1.
- STOP1: sampled_bit=0 sets stp_flag. If two_stop (latched) is set, go to STOP2; otherwise complete the frame.
- STOP2: sampled_bit=0 sets stp_flag, then complete the frame.
- Frame completion:
  - data_out loads the shift register.
  - data_vld pulses, with par_err=par_flag and stp_err=stp_flag.
  - par_err_cnt and stp_err_cnt increment for their set flags.
  - State returns to IDLE and both flags clear.
- A frame with errors is still delivered; the flags qualify it.
- Counters:
  - Each counter holds at all-ones and never wraps.
  - clr_cnt has priority over a same-cycle increment: the counter reads 0 afterwards.
- data_out holds its value until the next completed frame.

## Timing
- Reset values: state=IDLE, data_out=0, and every pulse output, busy and all counters are 0. Reset is asynchronous on assertion and released synchronously to clk.
- All outputs are registered. The response to a done sampled at edge N is visible after edge N; pulses are high for exactly the cycle following edge N.
- busy rises in the cycle after the start-bit done. It falls in the same cycle that data_vld is high.
- done on consecutive cycles is legal; each one advances one bit.
- The checker places no minimum spacing between frames. An IDLE done in the cycle right after completion is evaluated as a start bit.
- Reset mid-frame drops the frame. No data_vld follows.
- Config changes mid-frame have no effect until the next start bit.

## Test plan
- 8N1, line 0,0x5A LSB-first,1 → data_vld after last done, data_out=0x5A, par_err=0, stp_err=0, counters 0.
- 8E1 with a wrong parity bit: data 0x07 with parity 0 (even expects 1) → data_vld with par_err=1, par_err_cnt=1. Repeat as 8O1 with parity 0 → par_err=0.
- 8N2 with second stop sampled 0 → stp_err=1 and stp_err_cnt=1. Next frame 0xFF clean → stp_err=0, data_out=0xFF.
- Start sample 1 three times in IDLE → three strt_glitch pulses, glitch_cnt=3, busy stays 0. CNT_WIDTH=2 with five glitches → glitch_cnt=3 (saturated). clr_cnt together with a glitch → glitch_cnt=0.
- chk_en dropped after 4 data bits → IDLE next cycle, no data_vld, data_out unchanged. Then a full frame 0x3C → data_out=0x3C.
- DATA_WIDTH=9, parity on, rst asserted mid-frame → all outputs 0 immediately. Then a 0x1A5 frame with correct parity → data_out=0x1A5.

Source files
------------

// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: tracks frame position from per-bit sampler strobes,
// validates start/parity/stop, assembles the data word and keeps saturating error counters.
module uart_rx_frame_chk #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chk_en,
    input  logic                  done,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  two_stop,
    input  logic                  clr_cnt,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_vld,
    output logic                  strt_glitch,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  glitch_cnt,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, two_stop_q, two_stop_d;
    logic                  par_flag_q, par_flag_d, stp_flag_q, stp_flag_d;
    logic                  data_vld_q, data_vld_d, strt_glitch_q, strt_glitch_d;
    logic                  par_err_q, par_err_d, stp_err_q, stp_err_d, busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  glitch_cnt_q, glitch_cnt_d, par_cnt_q, par_cnt_d, stp_cnt_q, stp_cnt_d;
    logic                  inc_g, inc_p, inc_s, frame_done;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                      input logic inc, input logic clr);
        if (clr)
            return '0;
        if (inc && (cur != '1))
            return cur + CNT_WIDTH'(1);
        return cur;
    endfunction

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        two_stop_d    = two_stop_q;
        par_flag_d    = par_flag_q;
        stp_flag_d    = stp_flag_q;
        data_vld_d    = 1'b0;
        strt_glitch_d = 1'b0;
        par_err_d     = 1'b0;
        stp_err_d     = 1'b0;
        inc_g         = 1'b0;
        inc_p         = 1'b0;
        inc_s         = 1'b0;
        frame_done    = 1'b0;

        if (!chk_en) begin
            state_d    = IDLE;
            par_flag_d = 1'b0;
            stp_flag_d = 1'b0;
        end else if (done) begin
            case (state_q)
                IDLE: begin
                    if (!sampled_bit) begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        par_en_d   = par_en;
                        par_typ_d  = par_typ;
                        two_stop_d = two_stop;
                        par_flag_d = 1'b0;
                        stp_flag_d = 1'b0;
                    end else begin
                        strt_glitch_d = 1'b1;
                        inc_g         = 1'b1;
                    end
                end
                DATA: begin
                    shift_d[bit_cnt_q] = sampled_bit;
                    bit_cnt_d          = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == LAST_BIT)
                        state_d = par_en_q ? PARITY : STOP1;
                end
                PARITY: begin
                    if (sampled_bit != ((^shift_q) ^ par_typ_q))
                        par_flag_d = 1'b1;
                    state_d = STOP1;
                end
                STOP1: begin
                    if (!sampled_bit)
                        stp_flag_d = 1'b1;
                    if (two_stop_q)
                        state_d = STOP2;
                    else
                        frame_done = 1'b1;
                end
                STOP2: begin
                    if (!sampled_bit)
                        stp_flag_d = 1'b1;
                    frame_done = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        // Errored frames are still delivered; the flags qualify them.
        if (frame_done) begin
            data_out_d = shift_q;
            data_vld_d = 1'b1;
            par_err_d  = par_flag_d;
            stp_err_d  = stp_flag_d;
            inc_p      = par_flag_d;
            inc_s      = stp_flag_d;
            state_d    = IDLE;
            par_flag_d = 1'b0;
            stp_flag_d = 1'b0;
        end

        busy_d       = (state_d != IDLE);
        glitch_cnt_d = cnt_next(glitch_cnt_q, inc_g, clr_cnt);
        par_cnt_d    = cnt_next(par_cnt_q, inc_p, clr_cnt);
        stp_cnt_d    = cnt_next(stp_cnt_q, inc_s, clr_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            two_stop_q    <= 1'b0;
            par_flag_q    <= 1'b0;
            stp_flag_q    <= 1'b0;
            data_vld_q    <= 1'b0;
            strt_glitch_q <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            glitch_cnt_q  <= '0;
            par_cnt_q     <= '0;
            stp_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            two_stop_q    <= two_stop_d;
            par_flag_q    <= par_flag_d;
            stp_flag_q    <= stp_flag_d;
            data_vld_q    <= data_vld_d;
            strt_glitch_q <= strt_glitch_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
            busy_q        <= busy_d;
            glitch_cnt_q  <= glitch_cnt_d;
            par_cnt_q     <= par_cnt_d;
            stp_cnt_q     <= stp_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_vld    = data_vld_q;
    assign strt_glitch = strt_glitch_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;
    assign busy        = busy_q;
    assign glitch_cnt  = glitch_cnt_q;
    assign par_err_cnt = par_cnt_q;
    assign stp_err_cnt = stp_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Bench for uart_rx_frame_chk: three instances (default, 2-bit counters, 9-bit data)
// driven with directed and randomized frames and compared against a frame-level model.
module tb_uart_rx_frame_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, chk_en, done, done9, sampled_bit, par_en, par_typ, two_stop, clr_cnt;

    logic [7:0] dout0, dout1;
    logic [8:0] dout9;
    logic       vld0, gl0, pe0, se0, busy0;
    logic       vld1, gl1, pe1, se1, busy1;
    logic       vld9, gl9, pe9, se9, busy9;
    logic [7:0] gc0, pc0, sc0, gc9, pc9, sc9;
    logic [1:0] gc1, pc1, sc1;

    uart_rx_frame_chk #(.DATA_WIDTH(8), .CNT_WIDTH(8)) u0 (
        .clk(clk), .rst(rst), .chk_en(chk_en), .done(done), .sampled_bit(sampled_bit),
        .par_en(par_en), .par_typ(par_typ), .two_stop(two_stop), .clr_cnt(clr_cnt),
        .data_out(dout0), .data_vld(vld0), .strt_glitch(gl0), .par_err(pe0), .stp_err(se0),
        .busy(busy0), .glitch_cnt(gc0), .par_err_cnt(pc0), .stp_err_cnt(sc0));

    uart_rx_frame_chk #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u1 (
        .clk(clk), .rst(rst), .chk_en(chk_en), .done(done), .sampled_bit(sampled_bit),
        .par_en(par_en), .par_typ(par_typ), .two_stop(two_stop), .clr_cnt(clr_cnt),
        .data_out(dout1), .data_vld(vld1), .strt_glitch(gl1), .par_err(pe1), .stp_err(se1),
        .busy(busy1), .glitch_cnt(gc1), .par_err_cnt(pc1), .stp_err_cnt(sc1));

    uart_rx_frame_chk #(.DATA_WIDTH(9), .CNT_WIDTH(8)) u2 (
        .clk(clk), .rst(rst), .chk_en(chk_en), .done(done9), .sampled_bit(sampled_bit),
        .par_en(par_en), .par_typ(par_typ), .two_stop(two_stop), .clr_cnt(clr_cnt),
        .data_out(dout9), .data_vld(vld9), .strt_glitch(gl9), .par_err(pe9), .stp_err(se9),
        .busy(busy9), .glitch_cnt(gc9), .par_err_cnt(pc9), .stp_err_cnt(sc9));

    int vectors = 0;
    int miscompares = 0;

    // Model: raw event counts; the DUT view is the count clipped to the counter's range.
    int m_g, m_p, m_s, m_p9, m_s9;
    logic [8:0] last0, last9;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input bit w9);
        sampled_bit = b;
        done  = !w9;
        done9 = w9;
        cyc();
        done  = 1'b0;
        done9 = 1'b0;
    endtask

    task automatic check_counters();
        chk("glitch_cnt", 32'(gc0), 32'(sat(m_g, 255)));
        chk("par_cnt",    32'(pc0), 32'(sat(m_p, 255)));
        chk("stp_cnt",    32'(sc0), 32'(sat(m_s, 255)));
        chk("glitch_cnt_w2", 32'(gc1), 32'(sat(m_g, 3)));
        chk("par_cnt_w2",    32'(pc1), 32'(sat(m_p, 3)));
        chk("stp_cnt_w2",    32'(sc1), 32'(sat(m_s, 3)));
    endtask

    // One whole frame; the model derives parity/stop outcomes from the bits put on the line.
    task automatic frame(input logic [8:0] d, input bit w9, input bit pe, input bit pt,
                         input bit ts, input bit pflip, input bit s1, input bit s2,
                         input bit scramble);
        int         w;
        logic [8:0] dm;
        logic       pbit;
        bit         exp_par, exp_stp;
        w  = w9 ? 9 : 8;
        dm = w9 ? d : {1'b0, d[7:0]};
        par_en = pe; par_typ = pt; two_stop = ts;
        send(1'b0, w9);
        if (scramble) begin
            par_en   = 1'($urandom);
            par_typ  = 1'($urandom);
            two_stop = 1'($urandom);
        end
        chk("busy_in_frame", 32'(w9 ? busy9 : busy0), 32'd1);
        for (int i = 0; i < w; i++)
            send(dm[i], w9);
        if (pe) begin
            pbit = 1'(($countones(dm) % 2) != 0) ^ pt ^ pflip;
            send(pbit, w9);
        end
        send(s1, w9);
        if (ts)
            send(s2, w9);
        exp_par = pe && pflip;
        exp_stp = !s1 || (ts && !s2);
        if (w9) begin
            m_p9 += int'(exp_par);
            m_s9 += int'(exp_stp);
            last9 = dm;
            chk("vld9",   32'(vld9),  32'd1);
            chk("dout9",  32'(dout9), 32'(dm));
            chk("perr9",  32'(pe9),   32'(exp_par));
            chk("serr9",  32'(se9),   32'(exp_stp));
            chk("busy9",  32'(busy9), 32'd0);
            chk("pcnt9",  32'(pc9),   32'(sat(m_p9, 255)));
            chk("scnt9",  32'(sc9),   32'(sat(m_s9, 255)));
        end else begin
            m_p += int'(exp_par);
            m_s += int'(exp_stp);
            last0 = dm;
            chk("vld",   32'(vld0),  32'd1);
            chk("dout",  32'(dout0), 32'(dm[7:0]));
            chk("perr",  32'(pe0),   32'(exp_par));
            chk("serr",  32'(se0),   32'(exp_stp));
            chk("busy",  32'(busy0), 32'd0);
            chk("vld_w2", 32'(vld1), 32'd1);
            check_counters();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; chk_en = 1'b1; done = 1'b0; done9 = 1'b0; sampled_bit = 1'b1;
        par_en = 1'b0; par_typ = 1'b0; two_stop = 1'b0; clr_cnt = 1'b0;
        m_g = 0; m_p = 0; m_s = 0; m_p9 = 0; m_s9 = 0; last0 = '0; last9 = '0;
        cyc(); cyc();
        chk("rst_dout", 32'(dout0), 32'd0);
        chk("rst_vld",  32'(vld0),  32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_glitch", 32'(gl0), 32'd0);
        check_counters();
        rst = 1'b0;
        cyc();

        // 8N1 0x5A, then 8E1 bad parity, then 8O1 with the same line bits
        frame(9'h05A, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc();
        chk("vld_drop", 32'(vld0), 32'd0);
        chk("dout_hold", 32'(dout0), 32'h5A);
        frame(9'h007, 0, 1, 0, 0, 1, 1, 1, 0);
        frame(9'h007, 0, 1, 1, 0, 0, 1, 1, 0);

        // 8N2 with bad second stop, then clean 0xFF
        frame(9'h0A3, 0, 0, 0, 1, 0, 1, 0, 0);
        frame(9'h0FF, 0, 0, 0, 1, 0, 1, 1, 0);

        // Start glitches, saturation of the 2-bit counter, clear beating increment
        for (int k = 0; k < 5; k++) begin
            send(1'b1, 0);
            m_g++;
            chk("strt_glitch", 32'(gl0), 32'd1);
            chk("glitch_busy", 32'(busy0), 32'd0);
        end
        cyc();
        chk("glitch_drop", 32'(gl0), 32'd0);
        check_counters();
        clr_cnt = 1'b1;
        send(1'b1, 0);
        clr_cnt = 1'b0;
        m_g = 0; m_p = 0; m_s = 0; m_p9 = 0; m_s9 = 0;
        chk("clr_glitch_pulse", 32'(gl0), 32'd1);
        check_counters();

        // chk_en dropped mid-frame: frame abandoned, done ignored while disabled
        par_en = 1'b0; two_stop = 1'b0;
        send(1'b0, 0);
        for (int i = 0; i < 4; i++)
            send(1'b1, 0);
        chk_en = 1'b0;
        send(1'b0, 0);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_vld",  32'(vld0),  32'd0);
        chk("abort_dout", 32'(dout0), 32'(last0[7:0]));
        cyc();
        chk("abort_busy2", 32'(busy0), 32'd0);
        chk_en = 1'b1;
        frame(9'h03C, 0, 0, 0, 0, 0, 1, 1, 0);

        // Randomized frames: config, errors, glitches, gaps and mid-frame config noise
        for (int n = 0; n < 40; n++) begin
            int gap;
            if ($urandom_range(3) == 0) begin
                send(1'b1, 0);
                m_g++;
                chk("rnd_glitch", 32'(gl0), 32'd1);
            end
            frame(9'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(3) == 0, $urandom_range(4) != 0, $urandom_range(4) != 0,
                  1'($urandom));
            gap = int'($urandom_range(2));
            if (gap > 0) begin
                cyc();
                chk("rnd_vld_drop", 32'(vld0), 32'd0);
                chk("rnd_dout_hold", 32'(dout0), 32'(last0[7:0]));
                for (int g = 1; g < gap; g++)
                    cyc();
            end
        end
        check_counters();

        // 9-bit instance: clean frame, then reset mid-frame, then 0x1A5
        frame(9'h0F3, 1, 1, 0, 0, 0, 1, 1, 0);
        frame(9'h14C, 1, 1, 1, 1, 1, 1, 0, 0);
        par_en = 1'b1; par_typ = 1'b0;
        send(1'b0, 1);
        for (int i = 0; i < 5; i++)
            send(1'b1, 1);
        rst = 1'b1;
        #1;
        chk("arst_dout9", 32'(dout9), 32'd0);
        chk("arst_busy9", 32'(busy9), 32'd0);
        chk("arst_vld9",  32'(vld9),  32'd0);
        chk("arst_pcnt9", 32'(pc9),   32'd0);
        chk("arst_scnt9", 32'(sc9),   32'd0);
        chk("arst_dout0", 32'(dout0), 32'd0);
        m_g = 0; m_p = 0; m_s = 0; m_p9 = 0; m_s9 = 0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_vld9", 32'(vld9), 32'd0);
        frame(9'h1A5, 1, 1, 0, 0, 0, 1, 1, 0);
        frame(9'h1A5, 1, 1, 1, 0, 0, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
